// File: rtl/bg_sched_pkg.sv
// Shared types and constants for the background frame scheduler.
//   bg_mode_e     : image selection mode (manual requests or timed auto cycling)
//   ROM_ADDR_W    : background ROM address width
//   CALC_W        : width of the address-scaling intermediates
//   COORD_W       : DrawX/DrawY width
//   DEF_*         : default source image and screen geometry
package bg_sched_pkg;

  typedef enum logic {
    ModeManual,
    ModeAuto
  } bg_mode_e;

  localparam int unsigned ROM_ADDR_W = 17;
  localparam int unsigned CALC_W     = 27;
  localparam int unsigned COORD_W    = 10;

  localparam int unsigned DEF_IMG_W    = 175;
  localparam int unsigned DEF_IMG_H    = 480;
  localparam int unsigned DEF_SCREEN_W = 640;
  localparam int unsigned DEF_SCREEN_H = 480;

endpackage

// File: rtl/bg_addr_gen.sv
// Background ROM address stage and blank delay line.
// Scales the screen coordinate onto the source image and registers the
// resulting ROM address (1 cycle). blank is delayed 2 cycles so it lines up
// with the ROM data that comes back one cycle after the address.
// Ports:
//   vga_clk     in  pixel clock
//   reset       in  asynchronous, active-high
//   DrawX/DrawY in  current pixel column/row
//   blank       in  1 = visible pixel
//   rom_address out registered scaled address, 0 outside the visible area
//   pix_blank   out blank delayed 2 cycles
module bg_addr_gen
  import bg_sched_pkg::*;
#(
  parameter int unsigned IMG_W    = DEF_IMG_W,
  parameter int unsigned IMG_H    = DEF_IMG_H,
  parameter int unsigned SCREEN_W = DEF_SCREEN_W,
  parameter int unsigned SCREEN_H = DEF_SCREEN_H
) (
  input  logic                  vga_clk,
  input  logic                  reset,
  input  logic [COORD_W-1:0]    DrawX,
  input  logic [COORD_W-1:0]    DrawY,
  input  logic                  blank,
  output logic [ROM_ADDR_W-1:0] rom_address,
  output logic                  pix_blank
);

  logic [CALC_W-1:0]        w_x_scaled;
  logic [CALC_W-1:0]        w_row;
  logic [CALC_W-1:0]        w_addr;
  logic                     w_in_view;
  logic [CALC_W-ROM_ADDR_W-1:0] w_unused_hi;

  logic [ROM_ADDR_W-1:0]    r_rom_address;
  logic                     r_blank_d;
  logic                     r_pix_blank;

  always_comb begin
    w_x_scaled = (CALC_W'(DrawX) * CALC_W'(IMG_W)) / CALC_W'(SCREEN_W);
    w_row      = (CALC_W'(DrawY) * CALC_W'(IMG_H)) / CALC_W'(SCREEN_H);
    w_addr     = w_x_scaled + w_row * CALC_W'(IMG_W);
    w_in_view  = (32'(DrawX) < SCREEN_W) && (32'(DrawY) < SCREEN_H);
  end

  // Upper bits are always zero for in-range geometry.
  assign w_unused_hi = w_addr[CALC_W-1:ROM_ADDR_W];

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_rom_address <= '0;
      r_blank_d     <= 1'b0;
      r_pix_blank   <= 1'b0;
    end else begin
      r_rom_address <= w_in_view ? w_addr[ROM_ADDR_W-1:0] : '0;
      r_blank_d     <= blank;
      r_pix_blank   <= r_blank_d;
    end
  end

  assign rom_address = r_rom_address;
  assign pix_blank   = r_pix_blank;

endmodule

// File: rtl/bg_frame_scheduler.sv
// Background image scheduler: picks which of NUM_BG images drives the
// ROM/palette mux, switching only on frame boundaries.
// Optional feature macro: BG_SCHED_AUTO_EN builds the AUTO mode FSM and the
// frame-hold counter; without it the scheduler is manual-only and auto_en is
// ignored.
// Ports:
//   vga_clk, reset        pixel clock, asynchronous active-high reset
//   DrawX, DrawY, blank   raster position and visible flag
//   sel_req_valid/idx     manual select request, sel_req_ready = accepted
//   auto_en               request automatic cycling (sampled at frame_start)
//   bg_sel                current image index
//   rom_address           scaled ROM address (1 cycle after DrawX/DrawY)
//   pix_blank             blank delayed 2 cycles
//   frame_start           1-cycle pulse after the first pixel of a frame
module bg_frame_scheduler
  import bg_sched_pkg::*;
#(
  parameter int unsigned NUM_BG      = 4,
  parameter int unsigned IMG_W       = DEF_IMG_W,
  parameter int unsigned IMG_H       = DEF_IMG_H,
  parameter int unsigned SCREEN_W    = DEF_SCREEN_W,
  parameter int unsigned SCREEN_H    = DEF_SCREEN_H,
  parameter int unsigned HOLD_FRAMES = 60,
  localparam int unsigned IDX_W      = $clog2(NUM_BG)
) (
  input  logic                  vga_clk,
  input  logic                  reset,
  input  logic [COORD_W-1:0]    DrawX,
  input  logic [COORD_W-1:0]    DrawY,
  input  logic                  blank,
  input  logic                  sel_req_valid,
  input  logic [IDX_W-1:0]      sel_req_idx,
  output logic                  sel_req_ready,
  input  logic                  auto_en,
  output logic [IDX_W-1:0]      bg_sel,
  output logic [ROM_ADDR_W-1:0] rom_address,
  output logic                  pix_blank,
  output logic                  frame_start
);

  logic             w_origin;
  logic             w_auto_adv;
  logic [IDX_W-1:0] w_bg_sel_d;
  logic             w_pend_vld_d;
  logic [IDX_W-1:0] w_pend_idx_d;

  logic             r_origin;
  logic             r_frame_start;
  logic [IDX_W-1:0] r_bg_sel;
  logic             r_pend_vld;
  logic [IDX_W-1:0] r_pend_idx;

  assign w_origin = (DrawX == '0) && (DrawY == '0);

`ifdef BG_SCHED_AUTO_EN
  localparam int unsigned CNT_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  bg_mode_e         r_mode;
  bg_mode_e         w_mode_d;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;

  always_comb begin
    w_mode_d   = r_mode;
    w_cnt_d    = r_cnt;
    w_auto_adv = 1'b0;
    if (r_frame_start) begin
      w_mode_d = auto_en ? ModeAuto : ModeManual;
      unique case (r_mode)
        ModeManual: begin
          if (auto_en) w_cnt_d = '0;
        end
        ModeAuto: begin
          // A pending manual request wins over this frame's auto advance.
          if (r_pend_vld) begin
            w_cnt_d = '0;
          end else if (r_cnt == CNT_W'(HOLD_FRAMES - 1)) begin
            w_cnt_d    = '0;
            w_auto_adv = 1'b1;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
        default: w_mode_d = ModeManual;
      endcase
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_mode <= ModeManual;
      r_cnt  <= '0;
    end else begin
      r_mode <= w_mode_d;
      r_cnt  <= w_cnt_d;
    end
  end
`else
  // Manual-only build: the mode is permanently MANUAL.
  logic w_unused_auto_en;
  assign w_unused_auto_en = auto_en;
  assign w_auto_adv       = 1'b0;
`endif

  always_comb begin
    w_bg_sel_d   = r_bg_sel;
    w_pend_vld_d = r_pend_vld;
    w_pend_idx_d = r_pend_idx;
    if (r_frame_start && r_pend_vld) begin
      w_bg_sel_d   = r_pend_idx;
      w_pend_vld_d = 1'b0;
    end else begin
      if (r_frame_start && w_auto_adv) begin
        w_bg_sel_d = (r_bg_sel == IDX_W'(NUM_BG - 1)) ? '0 : r_bg_sel + 1'b1;
      end
      // Out-of-range indices complete the handshake but are dropped.
      if (sel_req_valid && !r_pend_vld && (32'(sel_req_idx) < NUM_BG)) begin
        w_pend_vld_d = 1'b1;
        w_pend_idx_d = sel_req_idx;
      end
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_origin      <= 1'b0;
      r_frame_start <= 1'b0;
      r_bg_sel      <= '0;
      r_pend_vld    <= 1'b0;
      r_pend_idx    <= '0;
    end else begin
      r_origin      <= w_origin;
      r_frame_start <= w_origin && !r_origin;
      r_bg_sel      <= w_bg_sel_d;
      r_pend_vld    <= w_pend_vld_d;
      r_pend_idx    <= w_pend_idx_d;
    end
  end

  assign sel_req_ready = !r_pend_vld;
  assign bg_sel        = r_bg_sel;
  assign frame_start   = r_frame_start;

  bg_addr_gen #(
    .IMG_W    (IMG_W),
    .IMG_H    (IMG_H),
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_addr_gen (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .rom_address (rom_address),
    .pix_blank   (pix_blank)
  );

endmodule

// File: tb/tb_bg_frame_scheduler.sv
// Testbench for bg_frame_scheduler: randomized raster/request stimulus with a
// frame-level reference model feeding a scoreboard queue; a monitor process
// pops one expectation per clock and compares every output. A second instance
// with NUM_BG=3 covers out-of-range request indices.
module tb_bg_frame_scheduler;

  localparam int NB = 4;
  localparam int HF = 3;
`ifdef BG_SCHED_AUTO_EN
  localparam bit AutoBuilt = 1'b1;
`else
  localparam bit AutoBuilt = 1'b0;
`endif

  logic        vga_clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        blank = 1'b0;
  logic        sel_req_valid = 1'b0;
  logic [1:0]  sel_req_idx = '0;
  logic        auto_en = 1'b0;
  logic        sel_req_ready;
  logic [1:0]  bg_sel;
  logic [16:0] rom_address;
  logic        pix_blank;
  logic        frame_start;

  logic        valid3 = 1'b0;
  logic [1:0]  idx3 = '0;
  logic        auto3 = 1'b0;
  logic        ready3;
  logic [1:0]  bg3;
  logic [16:0] rom3;
  logic        pb3;
  logic        fs3;

  always #5 vga_clk = ~vga_clk;

  bg_frame_scheduler #(.NUM_BG(NB), .HOLD_FRAMES(HF)) dut (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .sel_req_valid(sel_req_valid), .sel_req_idx(sel_req_idx), .sel_req_ready(sel_req_ready),
    .auto_en(auto_en), .bg_sel(bg_sel), .rom_address(rom_address), .pix_blank(pix_blank),
    .frame_start(frame_start)
  );

  bg_frame_scheduler #(.NUM_BG(3), .HOLD_FRAMES(HF)) dut3 (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .sel_req_valid(valid3), .sel_req_idx(idx3), .sel_req_ready(ready3),
    .auto_en(auto3), .bg_sel(bg3), .rom_address(rom3), .pix_blank(pb3),
    .frame_start(fs3)
  );

  typedef struct {
    int          cyc;
    logic [1:0]  bg;
    logic        rdy;
    logic        fs;
    logic [16:0] addr;
    logic        pb;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc_n = 0;

  // Reference model state, in frame/request terms.
  int   m_bg;
  int   m_pend;         // -1 = no pending request
  int   m_frames;       // frames shown since last switch in auto mode
  bit   m_auto;
  bit   m_fs;           // frame_start as currently visible
  bit   m_prev_origin;
  int   m_addr;
  bit   q_blank[$];     // blank samples, newest last

  function automatic void check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc_n, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_bg = 0; m_pend = -1; m_frames = 0; m_auto = 1'b0;
    m_fs = 1'b0; m_prev_origin = 1'b0; m_addr = 0;
    q_blank.delete();
  endfunction

  function automatic int ref_addr(int x, int y);
    if (x >= 640 || y >= 480) return 0;
    return (x * 175) / 640 + ((y * 480) / 480) * 175;
  endfunction

  // Effect of one clock edge given the inputs presented before it.
  function automatic void model_edge(int x, int y, bit b, bit v, int idx, bit ae);
    bit origin;
    bit was_ready;
    origin    = (x == 0 && y == 0);
    was_ready = (m_pend < 0);
    if (m_fs) begin
      if (m_pend >= 0) begin
        m_bg = m_pend; m_pend = -1; m_frames = 0;
      end else if (m_auto) begin
        m_frames++;
        if (m_frames == HF) begin
          m_bg = (m_bg + 1) % NB; m_frames = 0;
        end
      end
      if (AutoBuilt) begin
        if (!m_auto && ae) m_frames = 0;
        m_auto = ae;
      end
    end
    if (v && was_ready && idx < NB) m_pend = idx;
    m_fs = origin && !m_prev_origin;
    m_prev_origin = origin;
    m_addr = ref_addr(x, y);
    q_blank.push_back(b);
    if (q_blank.size() > 2) void'(q_blank.pop_front());
  endfunction

  task automatic cyc(int x, int y, bit b, bit v, int idx, bit ae);
    exp_t e;
    DrawX = 10'(x); DrawY = 10'(y); blank = b;
    sel_req_valid = v; sel_req_idx = 2'(idx); auto_en = ae;
    model_edge(x, y, b, v, idx, ae);
    @(posedge vga_clk);
    #1;
    cyc_n++;
    e.cyc  = cyc_n;
    e.bg   = 2'(m_bg);
    e.rdy  = (m_pend < 0);
    e.fs   = m_fs;
    e.addr = 17'(m_addr);
    e.pb   = (q_blank.size() == 2) ? q_blank[0] : 1'b0;
    sb_q.push_back(e);
    #1;
  endtask

  task automatic rcyc(bit v, int idx, bit ae);
    cyc($urandom_range(1, 700), $urandom_range(0, 500), 1'($urandom_range(0, 1)), v, idx, ae);
  endtask

  // One shortened frame; valid is held for cycles v_from..v_to.
  task automatic frame(int len, int v_from, int v_to, int idx, bit ae);
    for (int c = 0; c < len; c++) begin
      if (c == 0) cyc(0, 0, 1'b1, (v_from == 0), idx, ae);
      else rcyc((c >= v_from && c <= v_to), idx, ae);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge vga_clk);
      if (!reset && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("bg_sel", int'(bg_sel), int'(e.bg));
        check("sel_req_ready", int'(sel_req_ready), int'(e.rdy));
        check("frame_start", int'(frame_start), int'(e.fs));
        check("rom_address", int'(rom_address), int'(e.addr));
        check("pix_blank", int'(pix_blank), int'(e.pb));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    model_reset();
    repeat (2) @(posedge vga_clk);
    #2;
    check("reset_bg_sel", int'(bg_sel), 0);
    check("reset_ready", int'(sel_req_ready), 1);
    check("reset_frame_start", int'(frame_start), 0);
    check("reset_rom_address", int'(rom_address), 0);
    check("reset_pix_blank", int'(pix_blank), 0);
    reset = 1'b0;

    // Address corners and the blank delay line.
    cyc(639, 479, 1'b1, 1'b0, 0, 1'b0);
    cyc(320, 1, 1'b0, 1'b0, 0, 1'b0);
    cyc(640, 0, 1'b0, 1'b0, 0, 1'b0);
    cyc(5, 480, 1'b0, 1'b0, 0, 1'b0);
    cyc(100, 100, 1'b0, 1'b0, 0, 1'b0);
    cyc(101, 100, 1'b0, 1'b0, 0, 1'b0);

    // Manual select mid-frame, applied at the next frame.
    frame(6, 99, 99, 0, 1'b0);
    frame(8, 3, 3, 2, 1'b0);
    frame(6, 99, 99, 0, 1'b0);

    // Back-to-back: idx 1 accepted, idx 3 stalls across the frame boundary.
    for (int c = 0; c < 8; c++) begin
      if (c == 0) cyc(0, 0, 1'b1, 1'b0, 0, 1'b0);
      else rcyc((c == 2) || (c >= 4), (c == 2) ? 1 : 3, 1'b0);
    end
    for (int c = 0; c < 8; c++) begin
      if (c == 0) cyc(0, 0, 1'b1, 1'b1, 3, 1'b0);
      else rcyc(c <= 2, 3, 1'b0);
    end
    frame(6, 99, 99, 0, 1'b0);

    // Origin held for several cycles must give a single pulse.
    cyc(0, 0, 1'b1, 1'b0, 0, 1'b0);
    cyc(0, 0, 1'b1, 1'b0, 0, 1'b0);
    cyc(0, 0, 1'b1, 1'b0, 0, 1'b0);
    frame(5, 99, 99, 0, 1'b0);

    // Out-of-range index on the 3-image instance: accepted and dropped.
    cyc(0, 0, 1'b1, 1'b0, 0, 1'b0);
    rcyc(1'b0, 0, 1'b0);
    valid3 = 1'b1; idx3 = 2'd3;
    rcyc(1'b0, 0, 1'b0);
    valid3 = 1'b0;
    check("nb3_ready_after_bad_idx", int'(ready3), 1);
    repeat (3) rcyc(1'b0, 0, 1'b0);
    cyc(0, 0, 1'b1, 1'b0, 0, 1'b0);
    rcyc(1'b0, 0, 1'b0);
    check("nb3_bg_after_bad_idx", int'(bg3), 0);
    valid3 = 1'b1; idx3 = 2'd2;
    rcyc(1'b0, 0, 1'b0);
    valid3 = 1'b0;
    check("nb3_ready_after_good_idx", int'(ready3), 0);
    repeat (2) rcyc(1'b0, 0, 1'b0);
    cyc(0, 0, 1'b1, 1'b0, 0, 1'b0);
    rcyc(1'b0, 0, 1'b0);
    check("nb3_bg_after_good_idx", int'(bg3), 2);
    check("nb3_ready_after_apply", int'(ready3), 1);

    // Auto cycling through a full wrap, then a manual override.
    for (int f = 0; f < 14; f++) frame(5, 99, 99, 0, 1'b1);
    frame(5, 2, 2, 0, 1'b1);
    for (int f = 0; f < 4; f++) frame(5, 99, 99, 0, 1'b1);

    // Randomized frames, requests and mode changes.
    for (int f = 0; f < 60; f++) begin
      int len;
      int vf;
      len = $urandom_range(3, 10);
      vf  = $urandom_range(0, 12);
      frame(len, vf, vf + $urandom_range(0, 3), $urandom_range(0, NB - 1),
            ($urandom_range(0, 3) != 0));
    end

    // Reset mid-frame with a request pending.
    frame(6, 2, 2, 1, 1'b0);
    frame(6, 99, 99, 0, 1'b0);
    cyc(0, 0, 1'b1, 1'b0, 0, 1'b0);
    rcyc(1'b0, 0, 1'b0);
    rcyc(1'b1, 2, 1'b0);
    rcyc(1'b0, 0, 1'b0);
    #1;
    reset = 1'b1;
    sb_q.delete();
    #1;
    check("async_reset_bg_sel", int'(bg_sel), 0);
    check("async_reset_ready", int'(sel_req_ready), 1);
    check("async_reset_frame_start", int'(frame_start), 0);
    check("async_reset_rom_address", int'(rom_address), 0);
    check("async_reset_pix_blank", int'(pix_blank), 0);
    model_reset();
    @(posedge vga_clk);
    #2;
    reset = 1'b0;
    frame(6, 99, 99, 0, 1'b0);
    frame(6, 99, 99, 0, 1'b0);

    @(negedge vga_clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
